// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding.
package serial_arith_pkg;

    typedef logic [1:0] state_t;

    // 2'd3 is never entered; the next-state logic steers it back to idle.
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_SHIFT = 2'd1;
    localparam state_t S_DONE  = 2'd2;

    // Counter width for a WIDTH-bit serial operation; at least one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake plus operand and result buses of the serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    // Sequencing controller side.
    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    // Subtractor side.
    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/half_subtractor.sv
// One-bit half subtractor: d = x - y, bo = borrow out.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);
    assign d  = x ^ y;
    assign bo = ~x & y;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock,
// with a borrow flop carried between bit slices and a start/busy/done handshake.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             bin;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             busy;
    logic             done;

    // Full-subtract slice on the current LSBs: two half subtractors and an OR.
    logic d_ab;
    logic bo_ab;
    logic d_bit;
    logic bo_bin;
    logic bout;

    half_subtractor u_hs_ab (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .d  (d_ab),
        .bo (bo_ab)
    );

    half_subtractor u_hs_bin (
        .x  (d_ab),
        .y  (bin),
        .d  (d_bit),
        .bo (bo_bin)
    );

    assign bout     = bo_ab | bo_bin;
    assign last_bit = (cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: start only matters in idle, done lasts exactly one cycle.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start) state_nx = S_SHIFT;
            S_SHIFT: if (last_bit)  state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_SHIFT: busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand/result shift registers, borrow flop, bit counter and result holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            r_sh     <= '0;
            bin      <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (state == S_IDLE && bus.start) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            r_sh <= '0;
            bin  <= 1'b0;
            cnt  <= '0;
        end else if (state == S_SHIFT) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            r_sh <= {d_bit, r_sh[WIDTH-1:1]};
            bin  <= bout;
            if (last_bit) begin
                // Counter parks at zero so it never runs past WIDTH-1.
                cnt      <= '0;
                diff_q   <= {d_bit, r_sh[WIDTH-1:1]};
                borrow_q <= bout;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) with a result scoreboard.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;
    exp_t sb[$];
    logic [W-1:0] last_diff;
    logic         last_borrow;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: {borrow, diff} = {0,a} - {0,b}.
    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] full;
        exp_t e;
        full = {1'b0, a} - {1'b0, b};
        e.d  = full[W-1:0];
        e.bo = full[W];
        sb.push_back(e);
    endtask

    task automatic compare_result(input string tag);
        exp_t e;
        check({tag, "_sb_pending"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_diff"}, 32'(bus.diff), 32'(e.d));
            check({tag, "_borrow"}, 32'(bus.borrow_out), 32'(e.bo));
            last_diff   = e.d;
            last_borrow = e.bo;
        end
    endtask

    // Waits (bounded) for done; scrambles a/b while the DUT is mid-operation.
    task automatic wait_done(input string tag, output bit seen, output int edges, output int busy_n);
        seen   = 1'b0;
        edges  = 0;
        busy_n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy) busy_n++;
            if (bus.done) begin
                seen  = 1'b1;
                edges = i;
                break;
            end
            if (bus.busy) begin
                bus.a = 8'($urandom);
                bus.b = 8'($urandom);
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        bit seen;
        int edges;
        int busy_n;
        push_exp(a, b);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(bus.busy), 32'd1);
        check({tag, "_diff_hold"}, 32'(bus.diff), 32'(last_diff));
        check({tag, "_borrow_hold"}, 32'(bus.borrow_out), 32'(last_borrow));
        wait_done(tag, seen, edges, busy_n);
        if (seen) begin
            check({tag, "_latency"}, 32'(edges), 32'd8);
            check({tag, "_busy_cycles"}, 32'(busy_n + 1), 32'd9);
            compare_result(tag);
            @(posedge clk);
            #1;
            check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
            check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        end else begin
            void'(sb.pop_front());
        end
    endtask

    initial begin
        bit seen;
        int edges;
        int busy_n;
        logic [W-1:0] ha[4];
        logic [W-1:0] hb[4];

        tests       = 0;
        failed      = 0;
        last_diff   = '0;
        last_borrow = 1'b0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.a       = '0;
        bus.b       = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_diff", 32'(bus.diff), 32'd0);
        check("reset_borrow", 32'(bus.borrow_out), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases, including wrap-around and equal operands.
        do_op("op_05_03", 8'h05, 8'h03);
        do_op("op_03_05", 8'h03, 8'h05);
        do_op("op_00_01", 8'h00, 8'h01);
        do_op("op_ff_ff", 8'hFF, 8'hFF);
        do_op("op_80_7f", 8'h80, 8'h7F);

        // Result holds indefinitely in idle.
        repeat (5) @(posedge clk);
        #1;
        check("idle_hold_diff", 32'(bus.diff), 32'(last_diff));
        check("idle_hold_busy", 32'(bus.busy), 32'd0);

        // start held high: one acceptance every 10 cycles, start while busy ignored.
        ha = '{8'h10, 8'h22, 8'h01, 8'hC3};
        hb = '{8'h20, 8'h11, 8'hFE, 8'h3C};
        bus.start = 1'b1;
        bus.a     = ha[0];
        bus.b     = hb[0];
        push_exp(ha[0], hb[0]);
        for (int k = 0; k < 4; k++) begin
            wait_done($sformatf("held%0d", k), seen, edges, busy_n);
            if (!seen) begin
                void'(sb.pop_front());
                break;
            end
            check($sformatf("held%0d_interval", k), 32'(edges), (k == 0) ? 32'd9 : 32'd10);
            compare_result($sformatf("held%0d", k));
            if (k < 3) begin
                bus.a = ha[k+1];
                bus.b = hb[k+1];
                push_exp(ha[k+1], hb[k+1]);
            end else begin
                bus.start = 1'b0;
            end
        end
        @(posedge clk);
        #1;

        // Give the reset test a non-zero result to lose.
        do_op("pre_reset", 8'h55, 8'h11);

        // Reset asserted mid-shift: immediate clear, no done.
        bus.a     = 8'h09;
        bus.b     = 8'h04;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_diff", 32'(bus.diff), 32'd0);
        check("midrst_borrow", 32'(bus.borrow_out), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("midrst_nodone%0d", i), 32'(bus.done), 32'd0);
        end
        #3;
        rst_n = 1'b1;
        last_diff   = '0;
        last_borrow = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_idle_after", 32'(bus.busy), 32'd0);
        do_op("post_reset", 8'h09, 8'h04);

        // Randomised operands against the reference model.
        for (int i = 0; i < 200; i++) begin
            do_op($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom));
        end

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
